dac_write_arbiter: RTL and testbench

DAC_WRITE_ARBITER -- requirements
Module: dac_write_arbiter

---
 rtl/dac_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_dac_write_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_arbiter.sv
// Host/GS write FIFOs with round-robin commit into DAC sample and volume registers.
// Build option DAC_SD_VOLFORCE_EN: host sample commits also force that channel's volume to 63.
module dac_write_arbiter #(
  parameter int unsigned FIFO_AW = 1,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic       clk32,
  input  logic       rst_n,
  input  logic       h_req,
  input  logic [1:0] h_chn,
  input  logic [7:0] h_data,
  output logic       h_rdy,
  input  logic       g_req,
  input  logic       g_sel,
  input  logic [1:0] g_chn,
  input  logic [7:0] g_data,
  output logic       g_rdy,
  output logic [7:0] dac0,
  output logic [7:0] dac1,
  output logic [7:0] dac2,
  output logic [7:0] dac3,
  output logic [5:0] vol0,
  output logic [5:0] vol1,
  output logic [5:0] vol2,
  output logic [5:0] vol3,
  output logic [1:0] gnt,
  output logic [1:0] ovf,
  input  logic       ovf_clr
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef logic [FIFO_AW-1:0] ptr_t;
  typedef logic [FIFO_AW:0]   cnt_t;
  typedef logic [10:0]        entry_t;  // {sel, chn[1:0], data[7:0]}
  typedef enum logic {PRI_HOST = 1'b0, PRI_GS = 1'b1} pri_e;

  entry_t     mem_q [2][DEPTH];
  ptr_t       wp_q [2], wp_d [2], rp_q [2], rp_d [2];
  cnt_t       cnt_q [2], cnt_d [2];
  logic [1:0] rdy_q, rdy_d, req, ne, push, drop, pop;
  logic [1:0] gnt_q, gnt_d, ovf_q, ovf_d;
  pri_e       pri_q, pri_d;
  entry_t     wr_ent [2];
  entry_t     head;
  logic [7:0] dac_q [4], dac_d [4];
  logic [5:0] vol_q [4], vol_d [4];

  assign req       = {g_req, h_req};
  assign wr_ent[0] = {1'b0, h_chn, h_data};
  assign wr_ent[1] = {g_sel, g_chn, g_data};
  assign push      = req & rdy_q;
  assign drop      = req & ~rdy_q;
  assign ovf_d     = (ovf_q & ~{2{ovf_clr}}) | drop;
  assign gnt_d     = pop;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      ne[i] = (cnt_q[i] != '0);
    end
  end

  // Priority only rotates when both heads compete; a lone requester leaves it untouched.
  always_comb begin
    pop   = ne;
    pri_d = pri_q;
    if (&ne) begin
      if (pri_q == PRI_HOST) begin
        pop   = 2'b01;
        pri_d = PRI_GS;
      end else begin
        pop   = 2'b10;
        pri_d = PRI_HOST;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      wp_d[i]  = push[i] ? wp_q[i] + ptr_t'(1) : wp_q[i];
      rp_d[i]  = pop[i]  ? rp_q[i] + ptr_t'(1) : rp_q[i];
      cnt_d[i] = cnt_q[i];
      if (push[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end else if (!push[i] && pop[i]) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end
      rdy_d[i] = (cnt_d[i] < cnt_t'(DEPTH));
    end
  end

  assign head = pop[1] ? mem_q[1][rp_q[1]] : mem_q[0][rp_q[0]];

  always_comb begin
    dac_d = dac_q;
    vol_d = vol_q;
    if (|pop) begin
      if (head[10]) begin
        vol_d[head[9:8]] = head[5:0];
      end else begin
        dac_d[head[9:8]] = head[7] ? head[7:0] : {head[7], ~head[6:0]};
`ifdef DAC_SD_VOLFORCE_EN
        if (pop[0]) begin
          vol_d[head[9:8]] = '1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk32) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wp_q[i]] <= wr_ent[i];
      end
    end
  end

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      for (int unsigned c = 0; c < 4; c++) begin
        dac_q[c] <= '0;
        vol_q[c] <= '0;
      end
      rdy_q <= '1;
      gnt_q <= '0;
      ovf_q <= '0;
      pri_q <= pri_e'(RR_INIT);
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      dac_q <= dac_d;
      vol_q <= vol_d;
      rdy_q <= rdy_d;
      gnt_q <= gnt_d;
      ovf_q <= ovf_d;
      pri_q <= pri_d;
    end
  end

  assign h_rdy = rdy_q[0];
  assign g_rdy = rdy_q[1];
  assign gnt   = gnt_q;
  assign ovf   = ovf_q;
  assign dac0  = dac_q[0];
  assign dac1  = dac_q[1];
  assign dac2  = dac_q[2];
  assign dac3  = dac_q[3];
  assign vol0  = vol_q[0];
  assign vol1  = vol_q[1];
  assign vol2  = vol_q[2];
  assign vol3  = vol_q[3];

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Self-checking bench for dac_write_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_dac_write_arbiter;
  localparam int unsigned FIFO_AW = 1;
  localparam int unsigned DEPTH   = 2;
  localparam bit          RR_INIT = 1'b0;

  logic       clk32 = 1'b0;
  logic       rst_n = 1'b0;
  logic       h_req = 1'b0;
  logic [1:0] h_chn = '0;
  logic [7:0] h_data = '0;
  logic       g_req = 1'b0;
  logic       g_sel = 1'b0;
  logic [1:0] g_chn = '0;
  logic [7:0] g_data = '0;
  logic       ovf_clr = 1'b0;
  logic       h_rdy, g_rdy;
  logic [7:0] dac_w [4];
  logic [5:0] vol_w [4];
  logic [1:0] gnt, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] hq [$];
  logic [10:0] gq [$];
  bit          m_pri;
  logic [7:0]  m_dac [4];
  logic [5:0]  m_vol [4];
  logic [1:0]  m_gnt, m_ovf;

  dac_write_arbiter #(.FIFO_AW(FIFO_AW), .RR_INIT(RR_INIT)) dut (
    .clk32(clk32), .rst_n(rst_n),
    .h_req(h_req), .h_chn(h_chn), .h_data(h_data), .h_rdy(h_rdy),
    .g_req(g_req), .g_sel(g_sel), .g_chn(g_chn), .g_data(g_data), .g_rdy(g_rdy),
    .dac0(dac_w[0]), .dac1(dac_w[1]), .dac2(dac_w[2]), .dac3(dac_w[3]),
    .vol0(vol_w[0]), .vol1(vol_w[1]), .vol2(vol_w[2]), .vol3(vol_w[3]),
    .gnt(gnt), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk32 = ~clk32;

  // Unsigned-offset conversion: codes below 128 are mirrored around 127.
  function automatic logic [7:0] conv(input logic [7:0] d);
    int v;
    v = (d >= 128) ? int'(d) : 127 - int'(d);
    return 8'(v);
  endfunction

  function automatic void model_clear();
    hq.delete();
    gq.delete();
    m_pri = RR_INIT;
    m_gnt = '0;
    m_ovf = '0;
    for (int c = 0; c < 4; c++) begin
      m_dac[c] = '0;
      m_vol[c] = '0;
    end
  endfunction

  function automatic void model_edge(input logic hr, input logic [1:0] hc, input logic [7:0] hd,
                                     input logic gr, input logic gs, input logic [1:0] gc,
                                     input logic [7:0] gd, input logic clr);
    int          hn, gn, chn;
    logic [10:0] e;
    logic [1:0]  drops;
    hn    = hq.size();
    gn    = gq.size();
    m_gnt = 2'b00;
    e     = '0;
    if (hn > 0 && gn > 0) begin
      m_gnt = m_pri ? 2'b10 : 2'b01;
      m_pri = !m_pri;
    end else if (hn > 0) m_gnt = 2'b01;
    else if (gn > 0) m_gnt = 2'b10;
    if (m_gnt == 2'b01) e = hq.pop_front();
    if (m_gnt == 2'b10) e = gq.pop_front();
    if (m_gnt != 2'b00) begin
      chn = int'(e[9:8]);
      if (e[10]) m_vol[chn] = 6'(int'(e[7:0]) % 64);
      else begin
        m_dac[chn] = conv(e[7:0]);
`ifdef DAC_SD_VOLFORCE_EN
        if (m_gnt == 2'b01) m_vol[chn] = 6'd63;
`endif
      end
    end
    drops = 2'b00;
    if (hr) begin
      if (hn < DEPTH) hq.push_back({1'b0, hc, hd});
      else drops[0] = 1'b1;
    end
    if (gr) begin
      if (gn < DEPTH) gq.push_back({gs, gc, gd});
      else drops[1] = 1'b1;
    end
    m_ovf = clr ? drops : (m_ovf | drops);
  endfunction

  task automatic step(input logic hr, input logic [1:0] hc, input logic [7:0] hd,
                      input logic gr, input logic gs, input logic [1:0] gc,
                      input logic [7:0] gd, input logic clr);
    h_req = hr; h_chn = hc; h_data = hd;
    g_req = gr; g_sel = gs; g_chn = gc; g_data = gd;
    ovf_clr = clr;
    @(posedge clk32);
    model_edge(hr, hc, hd, gr, gs, gc, gd, clr);
    #1;
    h_req = 1'b0; g_req = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    h_req = 1'b0; g_req = 1'b0; ovf_clr = 1'b0;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk32);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (dac_w[c] !== 8'h00) begin n_fail++; $display("FAIL reset_dac%0d: got %h expected 00", c, dac_w[c]); end
      n_tests++; if (vol_w[c] !== 6'h00) begin n_fail++; $display("FAIL reset_vol%0d: got %h expected 00", c, vol_w[c]); end
    end
    n_tests++; if ({h_rdy, g_rdy} !== 2'b11) begin n_fail++; $display("FAIL reset_rdy: got %b expected 11", {h_rdy, g_rdy}); end
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_tests++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL reset_ovf: got %b expected 00", ovf); end
    step(1'b1, 2'd1, 8'h90, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL first_edge_gnt: got %b expected 00", gnt); end
    idle();
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL second_edge_gnt: got %b expected 01", gnt); end
    n_tests++; if (dac_w[1] !== 8'h90) begin n_fail++; $display("FAIL second_edge_dac1: got %h expected 90", dac_w[1]); end
  endtask

  task automatic test_single_host();
    do_reset();
    step(1'b1, 2'd2, 8'h80, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    n_tests++; if (dac_w[2] !== 8'h00) begin n_fail++; $display("FAIL single_early_dac2: got %h expected 00", dac_w[2]); end
    idle();
    n_tests++; if (dac_w[2] !== 8'h80) begin n_fail++; $display("FAIL single_dac2: got %h expected 80", dac_w[2]); end
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b expected 01", gnt); end
`ifdef DAC_SD_VOLFORCE_EN
    n_tests++; if (vol_w[2] !== 6'd63) begin n_fail++; $display("FAIL single_vol2: got %0d expected 63", vol_w[2]); end
`else
    n_tests++; if (vol_w[2] !== 6'd0) begin n_fail++; $display("FAIL single_vol2: got %0d expected 0", vol_w[2]); end
`endif
    idle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_idle_gnt: got %b expected 00", gnt); end
  endtask

  task automatic test_contention();
    do_reset();
    step(1'b1, 2'd0, 8'h05, 1'b1, 1'b0, 2'd1, 8'h12, 1'b0);
    idle();
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL contend_gnt1: got %b expected 01", gnt); end
    n_tests++; if (dac_w[0] !== 8'h7A) begin n_fail++; $display("FAIL contend_dac0: got %h expected 7a", dac_w[0]); end
    n_tests++; if (dac_w[1] !== 8'h00) begin n_fail++; $display("FAIL contend_dac1_early: got %h expected 00", dac_w[1]); end
    idle();
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL contend_gnt2: got %b expected 10", gnt); end
    n_tests++; if (dac_w[1] !== 8'h6D) begin n_fail++; $display("FAIL contend_dac1: got %h expected 6d", dac_w[1]); end
  endtask

  task automatic test_volume();
    logic [7:0] dac3_before;
    dac3_before = m_dac[3];
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd3, 8'hFF, 1'b0);
    idle();
    n_tests++; if (vol_w[3] !== 6'h3F) begin n_fail++; $display("FAIL vol3: got %h expected 3f", vol_w[3]); end
    n_tests++; if (dac_w[3] !== dac3_before) begin n_fail++; $display("FAIL vol_dac3: got %h expected %h", dac_w[3], dac3_before); end
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL vol_gnt: got %b expected 10", gnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1'b1, 2'd0, 8'h11, 1'b1, 1'b1, 2'd0, 8'h01, 1'b0);
    idle();  // host wins, GS now holds priority with one queued entry
    step(1'b1, 2'd0, 8'h81, 1'b1, 1'b1, 2'd1, 8'h02, 1'b0);
    n_tests++; if (h_rdy !== 1'b1) begin n_fail++; $display("FAIL ovf_rdy_after1: got %b expected 1", h_rdy); end
    step(1'b1, 2'd0, 8'h82, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    n_tests++; if (h_rdy !== 1'b0) begin n_fail++; $display("FAIL ovf_rdy_after2: got %b expected 0", h_rdy); end
    n_tests++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL ovf_before_drop: got %b expected 00", ovf); end
    step(1'b1, 2'd0, 8'h83, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    n_tests++; if (ovf !== 2'b01) begin n_fail++; $display("FAIL ovf_drop: got %b expected 01", ovf); end
    n_tests++; if (dac_w[0] !== 8'h81) begin n_fail++; $display("FAIL ovf_order1: got %h expected 81", dac_w[0]); end
    idle();
    n_tests++; if (dac_w[0] !== 8'h82) begin n_fail++; $display("FAIL ovf_order2: got %h expected 82", dac_w[0]); end
    idle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL ovf_drained_gnt: got %b expected 00", gnt); end
    n_tests++; if (dac_w[0] !== 8'h82) begin n_fail++; $display("FAIL ovf_no_third: got %h expected 82", dac_w[0]); end
  endtask

  task automatic test_ovf_clr();
    do_reset();
    repeat (4) step(1'b1, 2'd0, 8'hA0, 1'b1, 1'b0, 2'd1, 8'hB0, 1'b0);
    n_tests++; if (ovf !== 2'b11) begin n_fail++; $display("FAIL clr_both_set: got %b expected 11", ovf); end
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd1, 8'hB1, 1'b1);
    n_tests++; if (ovf !== 2'b10) begin n_fail++; $display("FAIL clr_vs_set: got %b expected 10", ovf); end
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    n_tests++; if (ovf !== 2'b00) begin n_fail++; $display("FAIL clr_plain: got %b expected 00", ovf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 2'd1, 8'h33, 1'b1, 1'b0, 2'd2, 8'h44, 1'b0);
    do_reset();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL mid_gnt: got %b expected 00", gnt); end
    n_tests++; if (dac_w[1] !== 8'h00 || dac_w[2] !== 8'h00) begin n_fail++; $display("FAIL mid_dac: got %h/%h expected 00/00", dac_w[1], dac_w[2]); end
    n_tests++; if ({h_rdy, g_rdy} !== 2'b11) begin n_fail++; $display("FAIL mid_rdy: got %b expected 11", {h_rdy, g_rdy}); end
    repeat (2) begin
      idle();
      n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL mid_no_commit: got %b expected 00", gnt); end
    end
    n_tests++; if (dac_w[1] !== 8'h00 || dac_w[2] !== 8'h00) begin n_fail++; $display("FAIL mid_dac_after: got %h/%h expected 00/00", dac_w[1], dac_w[2]); end
  endtask

  task automatic test_random();
    logic exp_hr, exp_gr;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           logic'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)), logic'($urandom_range(0, 15) == 0));
      exp_hr = (hq.size() < DEPTH);
      exp_gr = (gq.size() < DEPTH);
      n_tests++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc %0d: got %b expected %b", n, gnt, m_gnt); end
      n_tests++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d: got %b expected %b", n, ovf, m_ovf); end
      n_tests++; if ({h_rdy, g_rdy} !== {exp_hr, exp_gr}) begin n_fail++; $display("FAIL rnd_rdy cyc %0d: got %b expected %b", n, {h_rdy, g_rdy}, {exp_hr, exp_gr}); end
      for (int c = 0; c < 4; c++) begin
        n_tests++; if (dac_w[c] !== m_dac[c]) begin n_fail++; $display("FAIL rnd_dac%0d cyc %0d: got %h expected %h", c, n, dac_w[c], m_dac[c]); end
        n_tests++; if (vol_w[c] !== m_vol[c]) begin n_fail++; $display("FAIL rnd_vol%0d cyc %0d: got %h expected %h", c, n, vol_w[c], m_vol[c]); end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_host();
    test_contention();
    test_volume();
    test_overflow();
    test_ovf_clr();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
